// File: rtl/tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tx_fifo
// Brief    : 32-bit single-clock transmit FIFO with registered level/flags
//            and sticky overflow/underflow status for slow control.
// Revision : 1.0 - initial release
// ============================================================================
module tx_fifo #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic              clk40MHz_i,
  input  logic              rst_n_i,
  input  logic [DWIDTH-1:0] tx_fifo_wdata_i,
  input  logic              tx_fifo_wr_n_i,
  input  logic              tx_fifo_rd_n_i,
  output logic [DWIDTH-1:0] tx_fifo_rdata_o,
  output logic              tx_fifo_empty_o,
  output logic              tx_fifo_full_o,
  output logic              tx_fifo_afull_o,
  output logic [AWIDTH:0]   tx_fifo_level_o,
  output logic              tx_fifo_ovf_o,
  output logic              tx_fifo_udf_o,
  input  logic              clr_flags_i
);

  localparam int              c_depth    = 1 << AWIDTH;
  localparam logic [AWIDTH:0] c_one      = (AWIDTH+1)'(1);
  localparam logic [AWIDTH:0] c_af_level = (AWIDTH+1)'(AF_LEVEL);

  logic [DWIDTH-1:0] r_mem [c_depth];
  logic [AWIDTH:0]   r_wptr;
  logic [AWIDTH:0]   r_rptr;
  logic [AWIDTH:0]   r_level;
  logic [DWIDTH-1:0] r_rdata;
  logic              r_empty;
  logic              r_full;
  logic              r_afull;
  logic              r_ovf;
  logic              r_udf;

  logic              w_wr_acc;
  logic              w_rd_acc;
  logic              w_wr_err;
  logic              w_rd_err;
  logic [AWIDTH:0]   w_wptr_nxt;
  logic [AWIDTH:0]   w_rptr_nxt;
  logic [AWIDTH:0]   w_level_nxt;

  // Acceptance uses the registered flags, so strobes never reach flags combinationally.
  always_comb begin
    w_wr_acc    = ~tx_fifo_wr_n_i & ~r_full;
    w_rd_acc    = ~tx_fifo_rd_n_i & ~r_empty;
    w_wr_err    = ~tx_fifo_wr_n_i &  r_full;
    w_rd_err    = ~tx_fifo_rd_n_i &  r_empty;
    w_wptr_nxt  = w_wr_acc ? r_wptr + c_one : r_wptr;
    w_rptr_nxt  = w_rd_acc ? r_rptr + c_one : r_rptr;
    w_level_nxt = w_wptr_nxt - w_rptr_nxt;
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk40MHz_i) begin
    if (w_wr_acc) begin
      r_mem[r_wptr[AWIDTH-1:0]] <= tx_fifo_wdata_i;
    end
  end

  always_ff @(posedge clk40MHz_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_rdata <= '0;
      r_empty <= 1'b1;
      r_full  <= 1'b0;
      r_afull <= 1'b0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_level <= w_level_nxt;
      r_empty <= (w_level_nxt == '0);
      r_full  <= w_level_nxt[AWIDTH];
      r_afull <= (w_level_nxt >= c_af_level);
      if (w_rd_acc) begin
        r_rdata <= r_mem[r_rptr[AWIDTH-1:0]];
      end
      // A new error in the same cycle as a clear keeps the flag set.
      r_ovf   <= w_wr_err | (r_ovf & ~clr_flags_i);
      r_udf   <= w_rd_err | (r_udf & ~clr_flags_i);
    end
  end

  assign tx_fifo_rdata_o = r_rdata;
  assign tx_fifo_empty_o = r_empty;
  assign tx_fifo_full_o  = r_full;
  assign tx_fifo_afull_o = r_afull;
  assign tx_fifo_level_o = r_level;
  assign tx_fifo_ovf_o   = r_ovf;
  assign tx_fifo_udf_o   = r_udf;

endmodule
`default_nettype wire
